pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer and flag owner for the single-cycle core. Holds the PC and the
//  N/V/Z flag register, resolves conditional branches (B immediate, BR register) against the
//  registered flags, and advances the PC once per retired instruction. Handles fetch stalls,
//  HLT, and keeps retired/taken performance counters. Sits between decode/ALU and instr fetch.
// PARAMETERS
//  PC_W   16  PC / register-target width (bits)
//  IMM_W   9  B-type signed immediate width (halfword offset)
//  CNT_W  16  width of the saturating performance counters
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  instr_vld   in   1      current instruction fetched and decoded; retires this cycle if accepted
//  stall       in   1      freeze: no retire, PC/flags/counters hold
//  hlt         in   1      current instruction is HLT
//  br_req      in   1      current instruction is a branch (B or BR)
//  br_reg      in   1      1 = BR (target = reg_tgt), 0 = B (PC-relative imm)
//  cond        in   3      branch condition code
//  imm         in   IMM_W  signed branch offset, in halfwords
//  reg_tgt     in   PC_W   BR target address from register file
//  alu_flags   in   3      {N,V,Z} produced by current instruction
//  flag_we     in   3      per-bit write enable for {N,V,Z}
//  fetch_req   out  1      request fetch at pc
//  pc          out  PC_W   address of current instruction
//  pc_plus2    out  PC_W   pc + 2 (link value), combinational
//  flags       out  3      registered {N,V,Z}
//  br_taken    out  1      one-cycle pulse: a taken branch retired last cycle
//  halted      out  1      core halted
//  retired_cnt out  CNT_W  retired instructions, saturating
//  taken_cnt   out  CNT_W  taken branches, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=0, flags=3'b000, br_taken=0, halted=0, fetch_req=0, counters=0, state=BOOT.
//  - States: BOOT -> RUN after exactly one clk edge post-reset (fetch_req=0 in BOOT); RUN: fetch_req=1;
//    HALT: fetch_req=0, halted=1, sticky until reset. rst_n low in any state returns to BOOT.
//  - accept = (state==RUN) & instr_vld & ~stall. Without accept, pc/flags/counters hold, br_taken<=0.
//  - Condition (registered flags, N=flags[2], V=flags[1], Z=flags[0]):
//    000 Z=0 | 001 Z=1 | 010 Z=0&N=0 | 011 N=1 | 100 Z=1|(Z=0&N=0) | 101 N=1|Z=1 | 110 V=1 | 111 always.
//  - take = br_req & cond_true. Branch always uses flags BEFORE this instruction's flag write.
//  - Next PC on accept (mod 2^PC_W, wrap silently): hlt -> pc holds; take&~br_reg ->
//    pc+2+(sext(imm)<<1); take&br_reg -> reg_tgt; else pc+2.
//  - Flags on accept & ~hlt: flags[i] <= alu_flags[i] where flag_we[i]=1; others hold.
//  - hlt on accept: state->HALT next edge, flags unchanged, retired_cnt +1, no branch even if br_req=1.
//  - br_taken <= accept & take & ~hlt (1-cycle latency after the retiring edge).
//  - retired_cnt +1 per accept; taken_cnt +1 per taken branch; both saturate at all-ones.
//  - Inputs ignored in BOOT and HALT; stall has priority over instr_vld.
// TESTING
//  1 Reset, 1 cycle BOOT (fetch_req=0), then 3 non-branch instr -> pc 0,2,4,6; retired_cnt=3.
//  2 flags Z=1, pc=0x0010, B cond=001 imm=-3 -> pc=0x000C, br_taken pulse, taken_cnt=1;
//    same with Z=0 -> pc=0x0012, no pulse.
//  3 Branch cond=000 with flag_we=001, alu_flags Z=1 while old Z=0 -> taken on old Z; flags.Z=1 after.
//  4 pc=0xFFFE, non-branch -> pc=0x0000; BR cond=111 reg_tgt=0x1234 -> pc=0x1234.
//  5 stall=1 with instr_vld=1 for 4 cycles -> pc/flags/counters frozen; release -> single advance.
//  6 hlt with br_req=1 cond=111 at pc=0x0040 -> pc stays 0x0040, halted=1, fetch_req=0;
//    later instr_vld ignored; rst_n low mid-HALT -> pc=0, BOOT.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer and flag owner for the single-cycle core.
// Holds PC and {N,V,Z}, resolves B/BR against the registered flags,
// advances the PC once per retired instruction, and keeps saturating
// retired/taken performance counters.
module pc_sequencer #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IMM_W = 9,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_vld,
  input  logic             stall,
  input  logic             hlt,
  input  logic             br_req,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_tgt,
  input  logic [2:0]       alu_flags,
  input  logic [2:0]       flag_we,
  output logic             fetch_req,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic [2:0]       flags,
  output logic             br_taken,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic             br_taken_q, br_taken_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] taken_q, taken_d;

  logic             accept;
  logic             cond_true;
  logic             take;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_off;
  logic             flag_n, flag_v, flag_z;

  assign flag_n = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_z = flags_q[0];

  assign accept = (state_q == S_RUN) & instr_vld & ~stall;
  assign pc_inc = pc_q + PC_W'(2);
  // Sign-extend the halfword offset to PC width, then scale to bytes.
  assign br_off = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} << 1;

  // Evaluate branch condition against flags registered before this instruction.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000:  cond_true = ~flag_z;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = ~flag_z & ~flag_n;
      3'b011:  cond_true = flag_n;
      3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
      3'b101:  cond_true = flag_n | flag_z;
      3'b110:  cond_true = flag_v;
      default: cond_true = 1'b1;
    endcase
  end

  assign take = br_req & cond_true;

  // Next-state computation for state, PC, flags, pulse and counters.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    br_taken_d = 1'b0;
    retired_d  = retired_q;
    taken_d    = taken_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (accept && hlt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
    if (accept) begin
      if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
      if (!hlt) begin
        flags_d    = (flags_q & ~flag_we) | (alu_flags & flag_we);
        br_taken_d = take;
        if (take) begin
          pc_d = br_reg ? reg_tgt : pc_inc + br_off;
          if (taken_q != '1) taken_d = taken_q + CNT_W'(1);
        end else begin
          pc_d = pc_inc;
        end
      end
    end
  end

  // Architectural state registers, cleared asynchronously into BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= '0;
      flags_q    <= '0;
      br_taken_q <= 1'b0;
      retired_q  <= '0;
      taken_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      br_taken_q <= br_taken_d;
      retired_q  <= retired_d;
      taken_q    <= taken_d;
    end
  end

  assign fetch_req   = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign pc          = pc_q;
  assign pc_plus2    = pc_inc;
  assign flags       = flags_q;
  assign br_taken    = br_taken_q;
  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver applies directed and random
// instructions and pushes the model's expected post-edge state into a queue;
// a monitor pops one entry after every clock edge and compares.
module tb_pc_sequencer;

  localparam int PC_W  = 16;
  localparam int IMM_W = 9;
  localparam int CNT_W = 6;   // small so saturation is reachable
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_vld = 1'b0, stall = 1'b0, hlt = 1'b0;
  logic             br_req = 1'b0, br_reg = 1'b0;
  logic [2:0]       cond = '0, alu_flags = '0, flag_we = '0;
  logic [IMM_W-1:0] imm = '0;
  logic [PC_W-1:0]  reg_tgt = '0;
  logic             fetch_req, br_taken, halted;
  logic [PC_W-1:0]  pc, pc_plus2;
  logic [2:0]       flags;
  logic [CNT_W-1:0] retired_cnt, taken_cnt;

  pc_sequencer #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .stall(stall), .hlt(hlt),
    .br_req(br_req), .br_reg(br_reg), .cond(cond), .imm(imm), .reg_tgt(reg_tgt),
    .alu_flags(alu_flags), .flag_we(flag_we), .fetch_req(fetch_req), .pc(pc),
    .pc_plus2(pc_plus2), .flags(flags), .br_taken(br_taken), .halted(halted),
    .retired_cnt(retired_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_n, vld, stall, hlt, br, breg;
    int cond, imm, tgt, alu, we;
  } stim_t;

  typedef struct {
    int pc, fl, bt, halted, fr, ret, tkn;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  // Reference model: phase flags plus plain integer arithmetic.
  bit m_boot, m_run, m_halt;
  int m_pc, m_fl, m_bt, m_ret, m_tkn;

  function automatic bit cond_holds(int c, int fl);
    bit n, v, z;
    n = fl[2]; v = fl[1]; z = fl[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void model_step(stim_t s);
    bit acc, tk;
    int iv;
    if (!s.rst_n) begin
      m_boot = 1; m_run = 0; m_halt = 0;
      m_pc = 0; m_fl = 0; m_bt = 0; m_ret = 0; m_tkn = 0;
      return;
    end
    m_bt = 0;
    if (m_boot) begin
      m_boot = 0; m_run = 1;
      return;
    end
    if (!m_run) return;
    acc = s.vld && !s.stall;
    if (!acc) return;
    if (m_ret < CMAX) m_ret++;
    if (s.hlt) begin
      m_run = 0; m_halt = 1;
      return;
    end
    tk = s.br && cond_holds(s.cond, m_fl);
    m_fl = (m_fl & ~s.we & 7) | (s.alu & s.we);
    if (tk) begin
      iv = s.imm & 511;
      if (iv >= 256) iv -= 512;
      m_pc = s.breg ? (s.tgt & 'hFFFF) : ((m_pc + 2 + 2 * iv) & 'hFFFF);
      if (m_tkn < CMAX) m_tkn++;
      m_bt = 1;
    end else begin
      m_pc = (m_pc + 2) & 'hFFFF;
    end
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{rst_n: 1, vld: 1, stall: 0, hlt: 0, br: 0, breg: 0,
          cond: 0, imm: 0, tgt: 0, alu: 0, we: 0};
    return s;
  endfunction

  function automatic stim_t jmp(int tgt);
    stim_t s;
    s = nop(); s.br = 1; s.breg = 1; s.cond = 7; s.tgt = tgt;
    return s;
  endfunction

  function automatic stim_t setfl(int alu);
    stim_t s;
    s = nop(); s.alu = alu; s.we = 7;
    return s;
  endfunction

  // Apply one cycle's inputs at the falling edge and queue the expectation.
  task automatic drive(stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n     = s.rst_n;
    instr_vld = s.vld;   stall   = s.stall; hlt = s.hlt;
    br_req    = s.br;    br_reg  = s.breg;
    cond      = 3'(s.cond); imm  = IMM_W'(s.imm);
    reg_tgt   = PC_W'(s.tgt);
    alu_flags = 3'(s.alu); flag_we = 3'(s.we);
    model_step(s);
    e.pc = m_pc; e.fl = m_fl; e.bt = m_bt; e.halted = int'(m_halt);
    e.fr = int'(m_run); e.ret = m_ret; e.tkn = m_tkn;
    q.push_back(e);
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after it.
  initial begin
    exp_t e;
    while (!done || q.size() > 0) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",          int'(pc),          e.pc);
        chk("pc_plus2",    int'(pc_plus2),    (e.pc + 2) & 'hFFFF);
        chk("flags",       int'(flags),       e.fl);
        chk("br_taken",    int'(br_taken),    e.bt);
        chk("halted",      int'(halted),      e.halted);
        chk("fetch_req",   int'(fetch_req),   e.fr);
        chk("retired_cnt", int'(retired_cnt), e.ret);
        chk("taken_cnt",   int'(taken_cnt),   e.tkn);
      end
    end
  end

  initial begin
    stim_t s;
    int wait_cyc;
    // Reset, BOOT with ignored instruction, then three sequential instructions.
    s = nop(); s.rst_n = 0;
    drive(s); drive(s);
    drive(nop());
    repeat (3) drive(nop());
    // Z=1 at 0x0010, B cond=001 imm=-3 -> 0x000C; then Z=0 -> 0x0012.
    drive(setfl(3'b001));
    drive(jmp('h10));
    s = nop(); s.br = 1; s.cond = 1; s.imm = 'h1FD;
    drive(s);
    drive(jmp('h10));
    drive(setfl(3'b000));
    drive(s);
    // cond=000 decided on old Z=0 while the same instruction writes Z=1.
    s = nop(); s.br = 1; s.cond = 0; s.imm = 5; s.alu = 1; s.we = 1;
    drive(s);
    drive(nop());
    // Every condition code against a couple of flag patterns.
    for (int f = 0; f < 8; f += 3) begin
      drive(setfl(f));
      for (int c = 0; c < 8; c++) begin
        s = nop(); s.br = 1; s.cond = c; s.imm = 4;
        drive(s);
      end
    end
    // PC wrap at the top of the address space, then BR to 0x1234.
    drive(jmp('hFFFE));
    drive(nop());
    drive(jmp('h1234));
    // Stall holds everything for four cycles, release advances once.
    s = setfl(3'b101); s.stall = 1;
    repeat (4) drive(s);
    s.stall = 0;
    drive(s);
    // HLT with an always-taken branch at 0x0040; later instructions ignored.
    drive(jmp('h40));
    s = jmp('h999); s.hlt = 1; s.alu = 7; s.we = 7;
    drive(s);
    repeat (3) drive(jmp('h500));
    s = nop(); s.rst_n = 0;
    drive(s);
    drive(nop());
    // Counter saturation with a stream of taken branches.
    repeat (CMAX + 8) drive(jmp('h20));
    s = nop(); s.rst_n = 0;
    drive(s);
    // Randomized traffic with occasional resets and halts.
    for (int i = 0; i < 1500; i++) begin
      s.rst_n = ($urandom_range(0, 299) != 0);
      s.vld   = ($urandom_range(0, 3) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.hlt   = ($urandom_range(0, 119) == 0);
      s.br    = ($urandom_range(0, 1) == 0);
      s.breg  = ($urandom_range(0, 3) == 0);
      s.cond  = int'($urandom_range(0, 7));
      s.imm   = int'($urandom_range(0, 511));
      s.tgt   = int'($urandom_range(0, 65535)) & 'hFFFE;
      s.alu   = int'($urandom_range(0, 7));
      s.we    = int'($urandom_range(0, 7));
      drive(s);
    end
    done = 1'b1;
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
